// File: rtl/sensor_scan_scheduler.sv
// Scan sequencer for the on-chip sensing macros: per enabled channel it pulses the
// macro reset, waits a settle time, gates a saturating edge counter and posts the result.
module sensor_scan_scheduler #(
   parameter int unsigned CNT_W      = 16,
   parameter int unsigned NCH        = 4,
   parameter int unsigned RST_CYCLES = 8,
   parameter int unsigned TIME_W     = 16,
   localparam int unsigned CW        = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              start,
   input  logic              abort,
   input  logic              continuous,
   input  logic [NCH-1:0]    chan_mask,
   input  logic [TIME_W-1:0] settle_cycles,
   input  logic [TIME_W-1:0] window_cycles,
   input  logic              freq_in,
   output logic              macro_reset,
   output logic [CW-1:0]     chan_sel,
   output logic              busy,
   output logic              result_valid,
   output logic [CW-1:0]     result_chan,
   output logic [CNT_W-1:0]  result_data,
   output logic              result_ovf,
   output logic              scan_done,
   output logic              cfg_err
);

   localparam int unsigned RW = $clog2(RST_CYCLES + 1);
   localparam int unsigned TW = (TIME_W > RW) ? TIME_W : RW;

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StRst     = 3'd1;
   localparam logic [2:0] StSettle  = 3'd2;
   localparam logic [2:0] StMeasure = 3'd3;
   localparam logic [2:0] StStore   = 3'd4;
   localparam logic [2:0] StNext    = 3'd5;

   logic [2:0]        state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [CW-1:0]     chan_q, chan_d;
   logic [NCH-1:0]    mask_q;
   logic              cont_q;
   logic [TIME_W-1:0] settle_q, window_q;
   logic [2:0]        sync_q;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              ovf_q, ovf_d;
   logic [CW-1:0]     res_chan_q;
   logic [CNT_W-1:0]  res_data_q;
   logic              res_ovf_q;
   logic              cfg_err_q;

   logic          edge_det, start_ok, cfg_bad, last_meas;
   logic [CW-1:0] low_in, low_q, nxt;
   logic          has_nxt;
   logic [TW-1:0] rst_load, win_load;

   // sync_q[1] is the synchronised level, sync_q[2] its previous value
   assign edge_det  = sync_q[1] & ~sync_q[2];
   assign start_ok  = (state_q == StIdle) && start && !abort && (chan_mask != '0);
   assign cfg_bad   = (state_q == StIdle) && start && !abort && (chan_mask == '0);
   assign last_meas = (state_q == StMeasure) && (timer_q == '0);
   assign rst_load  = TW'(RST_CYCLES - 1);
   assign win_load  = (window_q == '0) ? '0 : TW'(window_q - 1'b1);

   // Descending scan so the lowest qualifying bit wins
   always_comb begin
      low_in  = '0;
      low_q   = '0;
      nxt     = '0;
      has_nxt = 1'b0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (chan_mask[i]) low_in = CW'(i);
         if (mask_q[i]) low_q = CW'(i);
         if (mask_q[i] && (CW'(i) > chan_q)) begin
            nxt     = CW'(i);
            has_nxt = 1'b1;
         end
      end
   end

   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      if (state_q != StMeasure) begin
         count_d = '0;
         ovf_d   = 1'b0;
      end else if (edge_det) begin
         if (&count_q) ovf_d = 1'b1;
         else count_d = count_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      chan_d  = chan_q;
      unique case (state_q)
         StIdle: begin
            if (start_ok) begin
               state_d = StRst;
               timer_d = rst_load;
               chan_d  = low_in;
            end
         end
         StRst: begin
            if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else if (settle_q == '0) begin
               state_d = StMeasure;
               timer_d = win_load;
            end else begin
               state_d = StSettle;
               timer_d = TW'(settle_q - 1'b1);
            end
         end
         StSettle: begin
            if (timer_q != '0) begin
               timer_d = timer_q - 1'b1;
            end else begin
               state_d = StMeasure;
               timer_d = win_load;
            end
         end
         StMeasure: begin
            if (timer_q != '0) timer_d = timer_q - 1'b1;
            else state_d = StStore;
         end
         StStore: state_d = StNext;
         StNext: begin
            if (has_nxt || cont_q) begin
               state_d = StRst;
               timer_d = rst_load;
               chan_d  = has_nxt ? nxt : low_q;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      if (abort) begin
         state_d = StIdle;
         chan_d  = chan_q;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q    <= StIdle;
         timer_q    <= '0;
         chan_q     <= '0;
         mask_q     <= '0;
         cont_q     <= 1'b0;
         settle_q   <= '0;
         window_q   <= '0;
         sync_q     <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         res_chan_q <= '0;
         res_data_q <= '0;
         res_ovf_q  <= 1'b0;
         cfg_err_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         chan_q    <= chan_d;
         sync_q    <= {sync_q[1:0], freq_in};
         count_q   <= count_d;
         ovf_q     <= ovf_d;
         cfg_err_q <= cfg_bad;
         if (start_ok) begin
            mask_q   <= chan_mask;
            cont_q   <= continuous;
            settle_q <= settle_cycles;
            window_q <= window_cycles;
         end
         // Capture includes an edge seen in the final measure cycle
         if (last_meas && !abort) begin
            res_chan_q <= chan_q;
            res_data_q <= count_d;
            res_ovf_q  <= ovf_d;
         end
      end
   end

   assign macro_reset  = (state_q == StIdle) || (state_q == StRst);
   assign chan_sel     = chan_q;
   assign busy         = (state_q != StIdle);
   assign result_valid = (state_q == StStore);
   assign result_chan  = res_chan_q;
   assign result_data  = res_data_q;
   assign result_ovf   = res_ovf_q;
   assign scan_done    = (state_q == StNext) && !has_nxt;
   assign cfg_err      = cfg_err_q;

endmodule

// File: doc/sensor_scan_scheduler.md
Name: sensor_scan_scheduler

Overview:
Sequences the on-chip sensing macros: VCO temperature sensor and LVDT front-end channels. For each enabled channel it:
- drives the analog channel select and the macro reset pulse,
- waits a settle interval,
- counts rising edges of the selected macro's frequency output over a programmable gate window,
- posts the count as a result.

Runs one scan or continuous round-robin scans. Sits between the Wishbone/LA register layer and the analog macro pins in user_project_wrapper.

Parameters:
CNT_W, 16, result counter width (saturating)
NCH, 4, number of scan channels (chan_sel width = clog2(NCH))
RST_CYCLES, 8, cycles macro_reset is held high per channel
TIME_W, 16, width of settle_cycles / window_cycles

Ports:
wb_clk_i  input  1  system clock
wb_rst_i  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begin scan (ignored unless IDLE)
abort  input  1  return to IDLE next cycle, no result
continuous  input  1  1 = repeat scans until abort
chan_mask  input  NCH  enabled channels, bit i = channel i
settle_cycles  input  TIME_W  post-reset settle time
window_cycles  input  TIME_W  gate window length; 0 treated as 1
freq_in  input  1  asynchronous macro frequency output (Fvco / LVDT comparator)
macro_reset  output  1  reset to analog macro
chan_sel  output  clog2(NCH)  selected channel
busy  output  1  high in any state except IDLE
result_valid  output  1  one-cycle strobe
result_chan  output  clog2(NCH)  channel of result
result_data  output  CNT_W  edge count
result_ovf  output  1  count saturated
scan_done  output  1  one-cycle pulse at end of a full scan (irq source)
cfg_err  output  1  one-cycle pulse: start with chan_mask==0

Behaviour:
Reset values:
- All outputs are 0 (chan_sel=0, result_data=0), except macro_reset=1.
- State is IDLE.
- Synchronizer and latched config are cleared.

Configuration latch:
- chan_mask, continuous, settle_cycles and window_cycles are latched on the accepted start.
- Later input changes have no effect until the next start.

freq_in path:
- 2-flop synchronizer, then rising-edge detector (3rd flop).
- An edge appears on the detector 3 cycles after the input transition.
- Detected edges are counted only while state is MEASURE.

FSM states and transitions (all transitions registered):
- IDLE: macro_reset=1.
  - start && chan_mask!=0: chan_sel := lowest set bit; go to RST.
  - start && chan_mask==0: cfg_err pulse; stay IDLE.
- RST: macro_reset=1 for exactly RST_CYCLES cycles, then SETTLE.
- SETTLE: macro_reset=0 for settle_cycles cycles; settle_cycles=0 skips directly to MEASURE. Edge counter cleared.
- MEASURE: lasts max(window_cycles,1) cycles; count += 1 per detected edge.
  - An edge detected in the final MEASURE cycle is counted.
  - Count saturates at 2^CNT_W-1 and sets the ovf flag.
- STORE: one cycle.
  - result_valid=1, result_chan=chan_sel, result_data/result_ovf = count/flag.
  - result_data/chan/ovf hold until the next STORE.
- NEXT: one cycle.
  - Select the next set bit above chan_sel, then go to RST.
  - If none, it is a wrap: scan_done pulse; then continuous ? (lowest set bit, RST) : IDLE.

Hold rules:
- chan_sel is stable from RST through STORE; it changes only in NEXT.

Latency:
- Start accepted at cycle t: macro_reset stays 1 through t+RST_CYCLES.
- result_valid fires at cycle t + RST_CYCLES + settle + window + 1.

abort:
- Any state goes to IDLE next cycle.
- No result_valid and no scan_done are generated.
- macro_reset returns to 1.
- Priority: abort > start. abort in IDLE has no effect.

Other boundary rules:
- start while busy is ignored.
- wb_rst_i mid-operation restores all reset values on the next edge; no strobes are emitted.
- A single-bit chan_mask scans that channel only; in continuous mode it repeats it with scan_done after every result.

Test Plan:
- chan_mask=0001, settle=4, window=100, single scan; drive 7 rising edges on freq_in, each 4 cycles high / 4 low, all inside MEASURE -> one result_valid: chan 0, data 7, ovf 0; scan_done the cycle after STORE; busy falls; latency from start = 8+4+100+1.
- chan_mask=1010, window=50, freq_in idle -> results chan 1 then chan 3, each data 0; macro_reset high 8 cycles before each channel; one scan_done; chan_sel never 0 or 2.
- CNT_W=4, window=200, freq_in period 8 cycles -> result_data=15, result_ovf=1.
- continuous=1, chan_mask=0100 -> repeated results on chan 2 with scan_done after each; abort mid-MEASURE -> IDLE next cycle, no further result_valid, macro_reset=1, busy=0.
- start with chan_mask=0 -> cfg_err one-cycle pulse, busy stays 0; start pulse while busy -> ignored, sequence unchanged.
- wb_rst_i asserted for 1 cycle during SETTLE -> all outputs at reset values next cycle, macro_reset=1; new start then runs a normal scan with window=0 giving a 1-cycle MEASURE.
